cordic_dir_decoder: RTL and testbench
=====================================

Name: cordic_dir_decoder

Overview:
- Reconstructs a rotation angle from the per-iteration direction bits ("operation": 1 = add, 0 = subtract) that the CORDIC direction logic produces.
- Each accepted bit adds or subtracts atan(2^-i) to a fixed-point accumulator, so the sigma sequence is decoded back into radians.
- Sits beside the vectoring-mode datapath. It produces the final angle plus an optional ±pi/2 quadrant pre-rotation captured at start.

Parameters:
- W, 32, angle width; two's-complement Q2.(W-2) radians
- ITER, 16, number of direction bits per operation (1..W-2)
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > ITER

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-low
- start  in  1  begin new decode; sampled only in IDLE
- pre_rot  in  2  quadrant pre-rotation, captured with start: 00 none, 01 +pi/2, 10 -pi/2, 11 treated as none
- op_valid  in  1  op_bit valid this cycle
- op_bit  in  1  direction bit: 1 = acc + atan(2^-i), 0 = acc - atan(2^-i)
- busy  out  1  high in ACCUM
- iter  out  CNT_W  index of next bit expected (0..ITER)
- done  out  1  one-cycle pulse: angle valid
- angle  out  W  decoded angle, held until next start

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low: rst=0 immediately forces state=IDLE, acc=0, angle=0, iter=0, busy=0, done=0.
- IDLE:
  - start=1 loads acc with +pi/2, -pi/2 or 0 per pre_rot, clears iter to 0, and moves to ACCUM next edge.
  - op_valid is ignored.
  - angle keeps its last value.
- ACCUM:
  - On each edge with op_valid=1: acc <= acc ± LUT[iter] per op_bit, and iter <= iter+1.
  - op_valid=0 stalls; no state change.
  - start is ignored.
  - When the bit at iter=ITER-1 is accepted, move to DONE.
- DONE (one cycle):
  - angle <= acc, done=1 for exactly this cycle, busy=0, then return to IDLE.
  - Latency: done rises the edge after the ITER-th accepted bit.
  - A start on the done cycle is ignored. Earliest accepted restart is the cycle after done.
- Arithmetic:
  - W-bit two's complement, wrapping modulo 2^W with no saturation.
  - The legal range |angle| ≤ pi/2 + 1.7433 would overflow Q2 only with pre_rot plus a full same-sign sequence. In that case wrap is accepted and documented behaviour.
- LUT:
  - entry i = round(atan(2^-i) · 2^(W-2)), round-to-nearest.
  - Entries for i ≥ W-2 are 0.
- busy = (state==ACCUM). The iter output is the live counter.
- Reset mid-ACCUM discards the partial accumulation. angle returns to 0, not to the previous result.

Decomposition:
- Package cordic_pkg holds:
  - state encoding IDLE/ACCUM/DONE
  - pre_rot codes
  - constants PI_HALF_Q30 = 32'h6487ED51 and the atan table literals for W=32
- Sub-module cordic_atan_lut: combinational, index in, W-bit atan(2^-i) out, table sourced from cordic_pkg.
- The decoder itself holds the FSM, counter and accumulator.

Test Plan:
- Reset: assert rst=0 mid-ACCUM after 5 bits → angle=0, iter=0, busy=0 immediately. After release, done stays 0 with no start.
- Two-bit check: start with pre_rot=00, bits 1,0 → after 2 bits internal acc = 32'h3243F6A9 - 32'h1DAC6705 = 32'h14978FA4. The final angle must match a golden model for the remaining bits.
- All-ones: 16 bits of 1 → angle = sum of LUT[0..15] ≈ 1.7433 rad (golden model, exact bits). done is high exactly one cycle, the edge after the 16th bit.
- Pre-rotation: pre_rot=10, bits 1 then 15×0 → angle = -pi/2 + LUT[0] - sum LUT[1..15], matching the golden model.
- Stall and ignore: random op_valid gaps in ACCUM → same result as gap-free. op_valid in IDLE has no effect. start in ACCUM and on the done cycle is ignored.
- Back-to-back: second start the cycle after done with a different sequence → the second angle is correct, and the first angle is held until that second done.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared encodings and Q2.30 constants for the CORDIC direction decoder.
// The table values are round(atan(2^-i) * 2^30); entries from i = 30 upwards are zero.
package cordic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        PR_NONE = 2'b00,
        PR_POS  = 2'b01,
        PR_NEG  = 2'b10,
        PR_RSVD = 2'b11
    } pre_rot_t;

    localparam logic [31:0] PI_HALF_Q30 = 32'h6487ED51;
    localparam int unsigned ATAN_N      = 32;

    localparam logic [31:0] ATAN_Q30 [ATAN_N] = '{
        32'h3243F6A9, 32'h1DAC6705, 32'h0FADBAFD, 32'h07F56EA7,
        32'h03FEAB77, 32'h01FFD55C, 32'h00FFFAAB, 32'h007FFF55,
        32'h003FFFEB, 32'h001FFFFD, 32'h00100000, 32'h00080000,
        32'h00040000, 32'h00020000, 32'h00010000, 32'h00008000,
        32'h00004000, 32'h00002000, 32'h00001000, 32'h00000800,
        32'h00000400, 32'h00000200, 32'h00000100, 32'h00000080,
        32'h00000040, 32'h00000020, 32'h00000010, 32'h00000008,
        32'h00000004, 32'h00000002, 32'h00000000, 32'h00000000
    };

    // Re-express a Q2.30 constant in Q2.(w-2); narrower formats round to nearest.
    function automatic logic [63:0] q30_rescale(input logic [31:0] v, input int unsigned w);
        logic [63:0] t;
        t = {32'd0, v};
        if (w >= 32)
            t = t << (w - 32);
        else
            t = (t + (64'd1 << (31 - w))) >> (32 - w);
        return t;
    endfunction

endpackage

// File: rtl/cordic_atan_lut.sv
// Combinational atan(2^-i) lookup in Q2.(W-2); indices at or beyond W-2 read as zero.
module cordic_atan_lut
    import cordic_pkg::*;
#(
    parameter int unsigned W     = 32,
    parameter int unsigned IDX_W = 5
) (
    input  logic [IDX_W-1:0] idx,
    output logic [W-1:0]     value
);

    int unsigned idx_u;

    always_comb begin
        idx_u = 32'(idx);
        value = '0;
        if (idx_u < W - 2 && idx_u < ATAN_N)
            value = W'(q30_rescale(ATAN_Q30[idx_u[4:0]], W));
    end

endmodule

// File: rtl/cordic_dir_decoder.sv
// Rebuilds a CORDIC rotation angle from the per-iteration direction bits,
// starting from an optional +/-pi/2 quadrant pre-rotation.
module cordic_dir_decoder
    import cordic_pkg::*;
#(
    parameter int unsigned W     = 32,
    parameter int unsigned ITER  = 16,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       pre_rot,
    input  logic             op_valid,
    input  logic             op_bit,
    output logic             busy,
    output logic [CNT_W-1:0] iter,
    output logic             done,
    output logic [W-1:0]     angle
);

    localparam logic [W-1:0]     PI_HALF  = W'(q30_rescale(PI_HALF_Q30, W));
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ITER - 1);

    state_t         state, state_next;
    logic [W-1:0]   acc;
    logic [W-1:0]   acc_step;
    logic [W-1:0]   acc_init;
    logic [W-1:0]   lut_val;
    logic           accept;
    logic           last_bit;

    cordic_atan_lut #(
        .W     (W),
        .IDX_W (CNT_W)
    ) u_lut (
        .idx   (iter),
        .value (lut_val)
    );

    always_comb begin
        accept   = (state == ST_ACCUM) && op_valid;
        last_bit = accept && (iter == LAST_IDX);
        acc_step = op_bit ? (acc + lut_val) : (acc - lut_val);
        case (pre_rot)
            PR_POS:  acc_init = PI_HALF;
            PR_NEG:  acc_init = -PI_HALF;
            default: acc_init = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = ST_ACCUM;
            ST_ACCUM: if (last_bit) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ST_ACCUM);
        done = (state == ST_DONE);
    end

    // angle takes the final sum on the same edge that enters DONE, so it is
    // already valid while the done pulse is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc   <= '0;
            iter  <= '0;
            angle <= '0;
        end else if (state == ST_IDLE && start) begin
            acc  <= acc_init;
            iter <= '0;
        end else if (accept) begin
            acc  <= acc_step;
            iter <= iter + CNT_W'(1);
            if (last_bit)
                angle <= acc_step;
        end
    end

endmodule

// File: tb/tb_cordic_dir_decoder.sv
// Self-checking bench for cordic_dir_decoder: a real-valued atan model predicts
// each angle at start time, and the prediction is checked when done pulses.
module tb_cordic_dir_decoder;

    localparam int unsigned W     = 32;
    localparam int unsigned ITER  = 16;
    localparam int unsigned CNT_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [1:0]       pre_rot;
    logic             op_valid;
    logic             op_bit;
    logic             busy;
    logic [CNT_W-1:0] iter;
    logic             done;
    logic [W-1:0]     angle;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] gold_lut [ITER];
    logic [31:0] gold_pi_half;
    logic [31:0] exp_q [$];
    logic [31:0] exp_v;
    logic [31:0] held;

    cordic_dir_decoder #(
        .W     (W),
        .ITER  (ITER),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .pre_rot  (pre_rot),
        .op_valid (op_valid),
        .op_bit   (op_bit),
        .busy     (busy),
        .iter     (iter),
        .done     (done),
        .angle    (angle)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] model(input logic [1:0] pr, input logic [15:0] bits);
        logic [31:0] a;
        case (pr)
            2'b01:   a = gold_pi_half;
            2'b10:   a = -gold_pi_half;
            default: a = 32'd0;
        endcase
        for (int i = 0; i < int'(ITER); i++)
            a = bits[i] ? a + gold_lut[i] : a - gold_lut[i];
        return a;
    endfunction

    task automatic start_op(input logic [1:0] pr, input logic [15:0] bits);
        exp_q.push_back(model(pr, bits));
        @(negedge clk);
        start   = 1'b1;
        pre_rot = pr;
        @(negedge clk);
        start   = 1'b0;
        pre_rot = 2'($urandom);
    endtask

    task automatic feed(input logic [15:0] bits, input int first, input int last,
                        input int gap_max, input logic start_noise);
        for (int i = first; i <= last; i++) begin
            if (gap_max > 0) begin
                repeat ($urandom_range(gap_max, 0)) begin
                    op_valid = 1'b0;
                    op_bit   = 1'($urandom);
                    start    = start_noise;
                    @(negedge clk);
                end
            end
            op_valid = 1'b1;
            op_bit   = bits[i];
            start    = start_noise;
            @(negedge clk);
        end
        op_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic test_reset;
        logic [15:0] bits;
        logic        seen;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({angle, iter, busy, done} !== {32'd0, 5'd0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_initial: angle=%h iter=%0d busy=%b done=%b, want 0/0/0/0",
                     angle, iter, busy, done);
        end
        @(negedge clk);
        rst = 1'b1;
        bits = 16'($urandom);
        start_op(2'b01, bits);
        feed(bits, 0, 15, 0, 1'b0);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (angle !== exp_v) begin
            n_bad++;
            $display("FAIL reset_preload_angle: got %h want %h", angle, exp_v);
        end
        @(negedge clk);
        bits = 16'($urandom);
        start_op(2'b00, bits);
        feed(bits, 0, 4, 0, 1'b0);
        n_cmp++;
        if (iter !== 5'd5 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_pre_abort: iter=%0d busy=%b want 5/1", iter, busy);
        end
        exp_q.delete();
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({angle, iter, busy, done} !== {32'd0, 5'd0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_mid_accum: angle=%h iter=%0d busy=%b done=%b, want 0/0/0/0",
                     angle, iter, busy, done);
        end
        @(negedge clk);
        rst  = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_no_spurious_done: activity seen=%b want 0", seen);
        end
    endtask

    task automatic test_two_bit;
        logic [15:0] bits;
        bits = {14'($urandom), 2'b01};
        start_op(2'b00, bits);
        feed(bits, 0, 1, 0, 1'b0);
        n_cmp++;
        if (iter !== 5'd2 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL two_bit_iter: iter=%0d busy=%b want 2/1", iter, busy);
        end
        feed(bits, 2, 15, 0, 1'b0);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (done !== 1'b1 || angle !== exp_v) begin
            n_bad++;
            $display("FAIL two_bit_angle: done=%b angle=%h want 1/%h", done, angle, exp_v);
        end
        n_cmp++;
        if (iter !== 5'(ITER)) begin
            n_bad++;
            $display("FAIL two_bit_final_iter: iter=%0d want %0d", iter, ITER);
        end
        @(negedge clk);
    endtask

    task automatic test_all_ones;
        start_op(2'b00, 16'hFFFF);
        feed(16'hFFFF, 0, 14, 0, 1'b0);
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL all_ones_early_done: done=%b busy=%b want 0/1", done, busy);
        end
        feed(16'hFFFF, 15, 15, 0, 1'b0);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || angle !== exp_v) begin
            n_bad++;
            $display("FAIL all_ones_angle: done=%b busy=%b angle=%h want 1/0/%h",
                     done, busy, angle, exp_v);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || angle !== exp_v) begin
            n_bad++;
            $display("FAIL all_ones_pulse: done=%b angle=%h want 0/%h", done, angle, exp_v);
        end
    endtask

    task automatic test_pre_rot;
        logic [1:0]  prs  [4];
        logic [15:0] bits [4];
        prs  = '{2'b10, 2'b01, 2'b11, 2'b10};
        bits = '{16'h0001, 16'($urandom), 16'($urandom), 16'hFFFF};
        for (int k = 0; k < 4; k++) begin
            start_op(prs[k], bits[k]);
            feed(bits[k], 0, 15, 0, 1'b0);
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (done !== 1'b1 || angle !== exp_v) begin
                n_bad++;
                $display("FAIL pre_rot_%0d: pre_rot=%b done=%b angle=%h want 1/%h",
                         k, prs[k], done, angle, exp_v);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stall_ignore;
        logic [15:0] bits;
        logic [4:0]  it0;
        held = angle;
        it0  = iter;
        repeat (4) begin
            op_valid = 1'b1;
            op_bit   = 1'($urandom);
            @(negedge clk);
        end
        op_valid = 1'b0;
        n_cmp++;
        if (iter !== it0 || busy !== 1'b0 || angle !== held) begin
            n_bad++;
            $display("FAIL idle_op_valid: iter=%0d busy=%b angle=%h want %0d/0/%h",
                     iter, busy, angle, it0, held);
        end
        bits = 16'($urandom);
        start_op(2'b01, bits);
        feed(bits, 0, 7, 3, 1'b1);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (iter !== 5'd8 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL stall_hold: iter=%0d busy=%b want 8/1", iter, busy);
        end
        feed(bits, 8, 15, 3, 1'b1);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (done !== 1'b1 || angle !== exp_v) begin
            n_bad++;
            $display("FAIL stall_angle: done=%b angle=%h want 1/%h", done, angle, exp_v);
        end
        start   = 1'b1;
        pre_rot = 2'b01;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || iter !== 5'(ITER) || angle !== exp_v) begin
            n_bad++;
            $display("FAIL start_on_done: busy=%b iter=%0d angle=%h want 0/%0d/%h",
                     busy, iter, angle, ITER, exp_v);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] b1, b2;
        b1 = 16'($urandom);
        b2 = ~b1 ^ 16'h00F0;
        start_op(2'b10, b1);
        feed(b1, 0, 15, 1, 1'b0);
        held = exp_q.pop_front();
        n_cmp++;
        if (done !== 1'b1 || angle !== held) begin
            n_bad++;
            $display("FAIL b2b_first: done=%b angle=%h want 1/%h", done, angle, held);
        end
        start_op(2'b01, b2);
        n_cmp++;
        if (busy !== 1'b1 || iter !== 5'd0) begin
            n_bad++;
            $display("FAIL b2b_restart: busy=%b iter=%0d want 1/0", busy, iter);
        end
        feed(b2, 0, 7, 2, 1'b0);
        n_cmp++;
        if (angle !== held || done !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_hold: angle=%h done=%b want %h/0", angle, done, held);
        end
        feed(b2, 8, 15, 2, 1'b0);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (done !== 1'b1 || angle !== exp_v) begin
            n_bad++;
            $display("FAIL b2b_second: done=%b angle=%h want 1/%h", done, angle, exp_v);
        end
        @(negedge clk);
    endtask

    initial begin
        real r;
        r = 1.0;
        for (int i = 0; i < int'(ITER); i++) begin
            gold_lut[i] = 32'($rtoi($atan(r) * 1073741824.0 + 0.5));
            r = r / 2.0;
        end
        gold_pi_half = 32'($rtoi(3.14159265358979323846 / 2.0 * 1073741824.0 + 0.5));
        start    = 1'b0;
        pre_rot  = 2'b00;
        op_valid = 1'b0;
        op_bit   = 1'b0;

        test_reset();
        test_two_bit();
        test_all_ones();
        test_pre_rot();
        test_stall_ignore();
        test_back_to_back();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
